// File: rtl/rssb_mc_core.sv
// Multi-cycle RSSB (reverse-subtract, skip-if-borrow) processor with a unified
// program/data RAM, host load port, memory-mapped PC/ACC/ZERO/IO/HALT and an output stream.
`timescale 1ns/1ps
module rssb_mc_core #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 256,
  parameter int START_PC = 16,
  parameter int CNT_W    = 16,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [WIDTH-1:0]  load_data,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [ADDR_W-1:0] pc,
  output logic [WIDTH-1:0]  acc,
  output logic [CNT_W-1:0]  instr_count
);

  localparam logic [ADDR_W-1:0] A_PC   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_ACC  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_ZERO = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_IO   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_HALT = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_RAM  = ADDR_W'(5);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_EXEC     = 3'd3,
    ST_OUT_WAIT = 3'd4,
    ST_HALT     = 3'd5
  } state_t;

  state_t              state_r;
  logic [WIDTH-1:0]    mem_r [DEPTH];
  logic [WIDTH-1:0]    rdata_r;
  logic [ADDR_W-1:0]   opaddr_r;

  logic [ADDR_W-1:0]   raddr_s;
  logic [ADDR_W-1:0]   dec_addr_s;
  logic [WIDTH-1:0]    operand_s;
  logic [WIDTH-1:0]    result_s;
  logic                neg_s;
  logic [ADDR_W:0]     pc_sum_s;
  logic [ADDR_W-1:0]   pc_next_s;
  logic                mem_we_s;
  logic [ADDR_W-1:0]   mem_waddr_s;
  logic [WIDTH-1:0]    mem_wdata_s;

  assign dec_addr_s = rdata_r[ADDR_W-1:0];

  // Operand selection, subtraction and skip-aware PC increment
  always_comb begin
    case (opaddr_r)
      A_PC:    operand_s = WIDTH'(pc);
      A_ACC:   operand_s = acc;
      A_ZERO:  operand_s = {WIDTH{1'b0}};
      A_IO:    operand_s = in_data;
      default: operand_s = rdata_r;
    endcase
    result_s = operand_s - acc;
    neg_s    = result_s[WIDTH-1];
    pc_sum_s = {1'b0, pc} + (neg_s ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1));
    if (pc_sum_s >= DEPTH_X) begin
      pc_next_s = ADDR_W'(pc_sum_s - DEPTH_X);
    end else begin
      pc_next_s = ADDR_W'(pc_sum_s);
    end
  end

  // RAM port steering: host loads only while not busy, otherwise the EXEC write-back
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = load_addr;
    mem_wdata_s = load_data;
    if (load_en && !busy) begin
      mem_we_s = 1'b1;
    end else if (state_r == ST_EXEC && opaddr_r >= A_RAM) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = opaddr_r;
      mem_wdata_s = result_s;
    end else begin
      mem_we_s = 1'b0;
    end
    if (state_r == ST_FETCH) begin
      raddr_s = pc;
    end else begin
      raddr_s = dec_addr_s;
    end
  end

  // Unified program/data RAM: synchronous write, registered read, never cleared
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
    rdata_r <= mem_r[raddr_s];
  end

  // Control FSM with registered status, architectural state and output stream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      pc          <= {ADDR_W{1'b0}};
      acc         <= {WIDTH{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= {WIDTH{1'b0}};
      instr_count <= {CNT_W{1'b0}};
      opaddr_r    <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            pc          <= ADDR_W'(START_PC);
            acc         <= {WIDTH{1'b0}};
            instr_count <= {CNT_W{1'b0}};
            done        <= 1'b0;
            busy        <= 1'b1;
            state_r     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          state_r <= ST_DECODE;
        end
        ST_DECODE: begin
          opaddr_r <= dec_addr_s;
          if (dec_addr_s == A_HALT) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= ST_HALT;
          end else begin
            state_r <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          acc <= result_s;
          // A PC write is a jump: the borrow skip does not apply
          if (opaddr_r == A_PC) begin
            pc <= result_s[ADDR_W-1:0];
          end else begin
            pc <= pc_next_s;
          end
          if (instr_count != {CNT_W{1'b1}}) begin
            instr_count <= instr_count + CNT_W'(1);
          end
          if (opaddr_r == A_IO) begin
            out_data  <= result_s;
            out_valid <= 1'b1;
            state_r   <= ST_OUT_WAIT;
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_OUT_WAIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= ST_FETCH;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rssb_mc_core.md
Name: rssb_mc_core

Overview:
Parametrised multi-cycle RSSB (reverse-subtract, skip-if-borrow) one-instruction processor with internal unified program/data memory.
- Adds a program-load port, start/busy/done control, memory-mapped PC/ACC/ZERO/IO/HALT locations, an output handshake and an instruction counter.
- Top-level compute core; a host loads a program, pulses start, then reads results via the output stream.

Parameters:
WIDTH, 8, data/accumulator word width (>= ADDR_W)
DEPTH, 256, memory words; ADDR_W = $clog2(DEPTH)
START_PC, 16, PC value loaded on start (must be >= 5)
CNT_W, 16, instruction counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  one-cycle pulse; begins execution when idle or halted
busy  output  1  high while executing
done  output  1  high from halt until next start or rst
load_en  input  1  memory write strobe, honoured only when busy=0
load_addr  input  ADDR_W  load address
load_data  input  WIDTH  load data
in_data  input  WIDTH  value returned by reads of address 3
out_valid  output  1  output word valid
out_ready  input  1  consumer accepts when out_valid & out_ready
out_data  output  WIDTH  output word
pc  output  ADDR_W  current program counter
acc  output  WIDTH  accumulator
instr_count  output  CNT_W  instructions retired since start

Behaviour:
- Reset (async, active-high): state IDLE; pc=0, acc=0, busy=0, done=0, out_valid=0, out_data=0, instr_count=0. Memory contents are not cleared. Reset mid-run aborts immediately.
- Memory: synchronous write, one-cycle registered read. Instruction word = operand address in bits [ADDR_W-1:0]; upper bits are ignored.
- Address map for operand reads and writes:
  - 0: reads PC; write sets PC.
  - 1: reads ACC.
  - 2: reads 0; writes discarded.
  - 3: reads in_data; write pushes to output.
  - 4: HALT.
  - 5..DEPTH-1: RAM.
- FSM states: IDLE, FETCH, DECODE, EXEC, OUT_WAIT, HALT.
- IDLE/HALT + start: pc=START_PC, acc=0, instr_count=0, done=0, busy=1, go to FETCH.
- start while busy is ignored. load_en while busy is ignored.
- FETCH: issue read mem[pc]; go to DECODE.
- DECODE: latch operand address a.
  - a=4: go to HALT, with busy=0 and done=1. instr_count is not incremented.
  - a>=5: issue read mem[a].
  - Otherwise: go to EXEC.
- EXEC:
  - Operand m comes from the map above.
  - r = (m - acc) mod 2^WIDTH; acc <= r; neg = r[WIDTH-1].
  - Write r to a: RAM write, special handling per map, or discard for address 2.
  - PC update:
    - a=0: pc <= r[ADDR_W-1:0], no skip.
    - Otherwise: pc <= pc+1, or pc+2 if neg, modulo DEPTH.
  - instr_count increments, saturating at all-ones.
  - a=3: out_data=r, out_valid=1, go to OUT_WAIT. Otherwise go to FETCH.
- OUT_WAIT: hold out_data/out_valid stable until out_ready. Handshake cycle clears out_valid and moves to FETCH.
- Latency: 3 cycles per RAM/special instruction; output instructions add at least 1 cycle (the handshake cycle).
- PC wraps DEPTH-1 -> 0, and DEPTH-1 -> 1 on skip.
- Simultaneous start and load_en when idle: both honoured; the load completes in the same cycle.

Test Plan:
- Load mem[16]=20, mem[20]=5, mem[17]=4; start -> mem[20]=5, acc=0x05, pc 16->17, halt; done=1, instr_count=1, 4 cycles from start to done.
- Borrow skip: acc=5 via previous, mem[18]=21, mem[21]=3 -> r=0xFE, mem[21]=0xFE, pc advances by 2.
- Output: acc=0x05, in_data=0x10, word 3 -> out_data=0x0B; out_ready low 3 cycles keeps out_valid=1 and out_data stable, pc frozen; released on the ready cycle.
- PC write: at pc=30, acc=0x0E, word 0 -> pc=0x10, no skip applied; zero address: word 2 with acc=0x03 -> acc=0xFD, nothing written, skip taken.
- Wrap: DEPTH=256, program at pc=255 non-neg -> pc=0; neg -> pc=1.
- Reset mid-run in EXEC -> outputs return to reset values asynchronously, RAM retains loaded data, and start reruns correctly; load_en during busy leaves memory unchanged.
